// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
//   Shared types and constants for the sector-transfer responder.
//   - sd_state_e   : responder FSM states (IDLE, WAIT, XFER, DONE)
//   - SECTOR_BYTES : bytes per sector
//   - SECTOR_AW    : width of the byte index within a sector
//   - lba_in_range : true when an LBA lies inside the 2^lba_bits image
// -----------------------------------------------------------------------------
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } sd_state_e;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_AW    = 9;

    // Any set bit above the mapped LBA range makes the request out of range.
    function automatic logic lba_in_range(input logic [31:0] lba,
                                          input int unsigned lba_bits);
        return (lba >> lba_bits) == 32'd0;
    endfunction

endpackage

// File: rtl/sd_byte_sequencer.sv
// -----------------------------------------------------------------------------
// sd_byte_sequencer
//   Walks the 512 bytes of one sector while run_i is high. Each byte takes
//   BYTE_CYCLES clocks: phase 0 issues the backing read (read direction) or
//   presents the byte index to the initiator buffer (write direction); phase 1
//   captures the returned byte. Captured data appears on the registered
//   outputs in the following cycle, so the final byte's strobe / write pulse
//   lands in the cycle after run_i drops.
//
// Ports
//   clk_i, reset_i       clock, synchronous active-high reset
//   run_i                transfer active (counters held at 0 when low)
//   rd_i                 1 = read (memory -> initiator), 0 = write
//   in_range_i           request LBA maps onto backing memory
//   lba_i                mapped LBA bits of the current request
//   mem_rdata_i          backing read data (valid the cycle after mem_rd_o)
//   sd_din_i             initiator buffer data (one cycle after sd_buff_addr_o)
//   sd_buff_addr_o       byte index toward the initiator
//   sd_dout_o            read data toward the initiator
//   sd_dout_strobe_o     one-cycle pulse, coincident with sd_dout_o
//   mem_addr_o           backing address {lba, byte}
//   mem_rd_o             backing read request
//   mem_we_o             backing write pulse
//   mem_wdata_o          backing write data
//   last_o               final cycle of the final byte period
// -----------------------------------------------------------------------------
module sd_byte_sequencer
    import sd_pkg::*;
#(
    parameter int          LBA_BITS    = 4,
    parameter int          BYTE_CYCLES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    run_i,
    input  logic                    rd_i,
    input  logic                    in_range_i,
    input  logic [LBA_BITS-1:0]     lba_i,
    input  logic [7:0]              mem_rdata_i,
    input  logic [7:0]              sd_din_i,
    output logic [SECTOR_AW-1:0]    sd_buff_addr_o,
    output logic [7:0]              sd_dout_o,
    output logic                    sd_dout_strobe_o,
    output logic [LBA_BITS+8:0]     mem_addr_o,
    output logic                    mem_rd_o,
    output logic                    mem_we_o,
    output logic [7:0]              mem_wdata_o,
    output logic                    last_o
);

    localparam int PH_W = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [SECTOR_AW-1:0] LAST_BYTE = SECTOR_AW'(SECTOR_BYTES - 1);

    logic [PH_W-1:0]          phase_q, phase_d;
    logic [SECTOR_AW-1:0]     byte_q, byte_d;
    logic                     strobe_q, strobe_d;
    logic [7:0]               dout_q, dout_d;
    logic [SECTOR_AW-1:0]     rd_addr_q, rd_addr_d;
    logic                     we_q, we_d;
    logic [7:0]               wdata_q, wdata_d;
    logic [LBA_BITS+8:0]      waddr_q, waddr_d;

    logic phase_first;
    logic phase_last;
    logic byte_last;
    logic capture;

    assign phase_first = (phase_q == '0);
    assign phase_last  = (phase_q == PH_W'(BYTE_CYCLES - 1));
    assign byte_last   = (byte_q == LAST_BYTE);
    assign capture     = run_i && (phase_q == PH_W'(1));

    always_comb begin
        phase_d   = phase_q;
        byte_d    = byte_q;
        strobe_d  = 1'b0;
        dout_d    = dout_q;
        rd_addr_d = rd_addr_q;
        we_d      = 1'b0;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;

        if (!run_i) begin
            phase_d = '0;
            byte_d  = '0;
        end else if (phase_last) begin
            phase_d = '0;
            // Hold at 511 so the counter never rolls into a second sector.
            if (!byte_last) begin
                byte_d = byte_q + SECTOR_AW'(1);
            end
        end else begin
            phase_d = phase_q + PH_W'(1);
        end

        if (capture && rd_i) begin
            strobe_d  = 1'b1;
            dout_d    = in_range_i ? mem_rdata_i : FILL_BYTE;
            rd_addr_d = byte_q;
        end else if (!run_i) begin
            // Outside a transfer the index returns to 0 once the last strobe
            // has been presented.
            rd_addr_d = '0;
        end

        if (capture && !rd_i) begin
            we_d    = in_range_i;
            wdata_d = sd_din_i;
            waddr_d = {lba_i, byte_q};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q   <= '0;
            byte_q    <= '0;
            strobe_q  <= 1'b0;
            dout_q    <= '0;
            rd_addr_q <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            waddr_q   <= '0;
        end else begin
            phase_q   <= phase_d;
            byte_q    <= byte_d;
            strobe_q  <= strobe_d;
            dout_q    <= dout_d;
            rd_addr_q <= rd_addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            waddr_q   <= waddr_d;
        end
    end

    // Write direction shows the live byte counter so the initiator buffer can
    // return sd_din one cycle later; read direction shows the index of the
    // byte currently on sd_dout.
    assign sd_buff_addr_o   = (run_i && !rd_i) ? byte_q : rd_addr_q;
    assign sd_dout_o        = dout_q;
    assign sd_dout_strobe_o = strobe_q;
    assign mem_rd_o         = run_i && rd_i && in_range_i && phase_first;
    assign mem_addr_o       = we_q ? waddr_q : {lba_i, byte_q};
    assign mem_we_o         = we_q;
    assign mem_wdata_o      = wdata_q;
    assign last_o           = run_i && phase_last && byte_last;

endmodule

// File: rtl/sd_block_responder.sv
// -----------------------------------------------------------------------------
// sd_block_responder
//   Responder end of the sd_lba / sd_rd / sd_wr / sd_ack sector protocol,
//   serving 512-byte sectors from a byte-wide synchronous backing memory, and
//   presenting an image on a mount pulse.
//
//   Handshake: a request is a level on sd_rd / sd_wr sampled only in IDLE
//   (read wins when both are high). sd_lba is latched on acceptance. sd_ack
//   rises ACK_DELAY cycles after acceptance and stays high for exactly
//   512*BYTE_CYCLES cycles; the initiator drops its request on the ack rise
//   and may raise the next one on the ack fall. Each read byte is delivered
//   by a one-cycle sd_dout_strobe with sd_dout/sd_buff_addr valid in the same
//   cycle; write bytes are fetched by presenting sd_buff_addr and sampling
//   sd_din one cycle later.
//
// Ports
//   clk_sys, reset       clock, synchronous active-high reset
//   sd_lba, sd_rd, sd_wr request from the initiator
//   sd_ack               transfer in progress
//   sd_buff_addr         byte index within the sector
//   sd_dout, sd_dout_strobe  read data and its valid pulse
//   sd_din               initiator buffer data
//   mem_addr, mem_rd, mem_rdata, mem_we, mem_wdata  backing memory port
//   mount, img_mounted, img_size  image presentation
//   err                  one-cycle pulse on an out-of-range request
//   dbg_state            current FSM state (sd_state_e encoding)
// -----------------------------------------------------------------------------
module sd_block_responder
    import sd_pkg::*;
#(
    parameter int          LBA_BITS    = 4,
    parameter int          ACK_DELAY   = 4,
    parameter int          BYTE_CYCLES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [31:0]             sd_lba,
    input  logic                    sd_rd,
    input  logic                    sd_wr,
    output logic                    sd_ack,
    output logic [8:0]              sd_buff_addr,
    output logic [7:0]              sd_dout,
    output logic                    sd_dout_strobe,
    input  logic [7:0]              sd_din,
    output logic [LBA_BITS+8:0]     mem_addr,
    output logic                    mem_rd,
    input  logic [7:0]              mem_rdata,
    output logic                    mem_we,
    output logic [7:0]              mem_wdata,
    input  logic                    mount,
    output logic                    img_mounted,
    output logic [31:0]             img_size,
    output logic                    err,
    output logic [1:0]              dbg_state
);

    localparam int          WAIT_W    = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam logic [31:0] IMG_BYTES = 32'(SECTOR_BYTES) << LBA_BITS;

    sd_state_e              state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [LBA_BITS-1:0]    lba_q, lba_d;
    logic                   rd_q, rd_d;
    logic                   in_range_q, in_range_d;
    logic                   err_q, err_d;
    logic [31:0]            img_size_q, img_size_d;
    logic                   mount_dly_q;
    logic                   img_mounted_q;

    logic                   req_in_range;
    logic                   run;
    logic                   last;

    assign req_in_range = lba_in_range(sd_lba, LBA_BITS);
    assign run          = (state_q == XFER);

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        lba_d      = lba_q;
        rd_d       = rd_q;
        in_range_d = in_range_q;
        err_d      = 1'b0;
        img_size_d = mount ? IMG_BYTES : img_size_q;

        case (state_q)
            IDLE: begin
                if (sd_rd || sd_wr) begin
                    state_d    = WAIT;
                    lba_d      = sd_lba[LBA_BITS-1:0];
                    rd_d       = sd_rd;
                    in_range_d = req_in_range;
                    err_d      = !req_in_range;
                end
            end
            WAIT: begin
                if (wait_q == WAIT_W'(ACK_DELAY - 1)) begin
                    state_d = XFER;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            XFER: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            lba_q         <= '0;
            rd_q          <= 1'b0;
            in_range_q    <= 1'b0;
            err_q         <= 1'b0;
            img_size_q    <= '0;
            mount_dly_q   <= 1'b0;
            img_mounted_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            lba_q         <= lba_d;
            rd_q          <= rd_d;
            in_range_q    <= in_range_d;
            err_q         <= err_d;
            img_size_q    <= img_size_d;
            // img_size moves first, img_mounted follows a cycle later so the
            // consumer always sees the new size when the pulse arrives.
            mount_dly_q   <= mount;
            img_mounted_q <= mount_dly_q;
        end
    end

    sd_byte_sequencer #(
        .LBA_BITS    (LBA_BITS),
        .BYTE_CYCLES (BYTE_CYCLES),
        .FILL_BYTE   (FILL_BYTE)
    ) u_seq (
        .clk_i            (clk_sys),
        .reset_i          (reset),
        .run_i            (run),
        .rd_i             (rd_q),
        .in_range_i       (in_range_q),
        .lba_i            (lba_q),
        .mem_rdata_i      (mem_rdata),
        .sd_din_i         (sd_din),
        .sd_buff_addr_o   (sd_buff_addr),
        .sd_dout_o        (sd_dout),
        .sd_dout_strobe_o (sd_dout_strobe),
        .mem_addr_o       (mem_addr),
        .mem_rd_o         (mem_rd),
        .mem_we_o         (mem_we),
        .mem_wdata_o      (mem_wdata),
        .last_o           (last)
    );

    assign sd_ack      = run;
    assign err         = err_q;
    assign img_size    = img_size_q;
    assign img_mounted = img_mounted_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sd_block_responder.sv
module tb_sd_block_responder;

    localparam int         LBA_BITS    = 4;
    localparam int         ACK_DELAY   = 4;
    localparam int         BYTE_CYCLES = 2;
    localparam int         XFER_CYC    = 512 * BYTE_CYCLES;
    localparam int         MEM_BYTES   = 512 << LBA_BITS;

    // ---------------- clock / reset ----------------
    logic clk_sys;
    logic reset;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // ---------------- DUT ----------------
    logic [31:0]          sd_lba;
    logic                 sd_rd, sd_wr;
    logic                 sd_ack;
    logic [8:0]           sd_buff_addr;
    logic [7:0]           sd_dout;
    logic                 sd_dout_strobe;
    logic [7:0]           sd_din;
    logic [LBA_BITS+8:0]  mem_addr;
    logic                 mem_rd;
    logic [7:0]           mem_rdata;
    logic                 mem_we;
    logic [7:0]           mem_wdata;
    logic                 mount;
    logic                 img_mounted;
    logic [31:0]          img_size;
    logic                 err;
    logic [1:0]           dbg_state;

    sd_block_responder #(
        .LBA_BITS    (LBA_BITS),
        .ACK_DELAY   (ACK_DELAY),
        .BYTE_CYCLES (BYTE_CYCLES),
        .FILL_BYTE   (8'hFF)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .sd_ack         (sd_ack),
        .sd_buff_addr   (sd_buff_addr),
        .sd_dout        (sd_dout),
        .sd_dout_strobe (sd_dout_strobe),
        .sd_din         (sd_din),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_rdata      (mem_rdata),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mount          (mount),
        .img_mounted    (img_mounted),
        .img_size       (img_size),
        .err            (err),
        .dbg_state      (dbg_state)
    );

    // ---------------- environment models ----------------
    logic [7:0] mem [MEM_BYTES];
    logic [7:0] buf_seed;

    always @(posedge clk_sys) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Initiator buffer: one-cycle read latency against sd_buff_addr.
    always @(posedge clk_sys) sd_din <= buf_seed ^ sd_buff_addr[7:0];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [16:0] rd_exp_q[$];   // {buff_addr, data}
    logic [20:0] wr_exp_q[$];   // {mem_addr, data}
    logic [16:0] rd_e;
    logic [20:0] wr_e;
    int extra_strobe = 0;
    int extra_we     = 0;
    int rd_cnt       = 0;
    int err_cnt      = 0;
    int mnt_cnt      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        if (sd_dout_strobe) begin
            if (rd_exp_q.size() == 0) begin
                extra_strobe++;
            end else begin
                rd_e = rd_exp_q.pop_front();
                check_eq("rd_byte", {15'd0, sd_buff_addr, sd_dout}, {15'd0, rd_e});
            end
        end
        if (mem_we) begin
            if (wr_exp_q.size() == 0) begin
                extra_we++;
            end else begin
                wr_e = wr_exp_q.pop_front();
                check_eq("wr_byte", {11'd0, mem_addr, mem_wdata}, {11'd0, wr_e});
            end
        end
        if (mem_rd)      rd_cnt++;
        if (err)         err_cnt++;
        if (img_mounted) mnt_cnt++;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [7:0] save_seed(input int s);
        return 8'(s * 8'h11) ^ 8'hA5;
    endfunction

    function automatic logic [7:0] preload(input logic [12:0] a);
        return {a[12:9], a[3:0]};
    endfunction

    task automatic push_read(input logic [3:0] hi, input bit fill);
        for (int k = 0; k < 512; k++) begin
            logic [8:0] kk;
            kk = 9'(k);
            rd_exp_q.push_back({kk, fill ? 8'hFF : {hi, kk[3:0]}});
        end
    endtask

    task automatic push_write(input logic [3:0] lba, input logic [7:0] seed,
                              input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            logic [8:0] kk;
            kk = 9'(k);
            wr_exp_q.push_back({lba, kk, seed ^ kk[7:0]});
        end
    endtask

    // Raise a request (caller is #1 after a rising edge) and follow it through
    // the ack window. pre_edges = edges between raising and acceptance + 1.
    task automatic run_xfer(input logic rd, input logic wr, input logic [31:0] lba,
                            input int pre_edges);
        int n;
        sd_lba = lba;
        sd_rd  = rd;
        sd_wr  = wr;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_sys); #1;
            n++;
            if (sd_ack) break;
        end
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        check_eq("ack_delay", 32'(n - pre_edges), ACK_DELAY);
        n = 1;
        for (int i = 0; i < 2 * XFER_CYC; i++) begin
            @(posedge clk_sys); #1;
            if (!sd_ack) break;
            n++;
        end
        check_eq("ack_len", 32'(n), XFER_CYC);
    endtask

    task automatic settle(input string tag);
        repeat (3) @(posedge clk_sys);
        #1;
        check_eq({tag, "_rdq"}, 32'(rd_exp_q.size()), 0);
        check_eq({tag, "_wrq"}, 32'(wr_exp_q.size()), 0);
        check_eq({tag, "_xstb"}, 32'(extra_strobe), 0);
        check_eq({tag, "_xwe"}, 32'(extra_we), 0);
        check_eq({tag, "_state"}, {30'd0, dbg_state}, 0);
        check_eq({tag, "_baddr"}, {23'd0, sd_buff_addr}, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        reset = 1'b1; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0;
        mount = 1'b0; buf_seed = 8'h00; mem_rdata = 8'h00;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = preload(13'(i));
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;

        // Reset state
        check_eq("rst_ack", {31'd0, sd_ack}, 0);
        check_eq("rst_img_size", img_size, 0);
        check_eq("rst_baddr", {23'd0, sd_buff_addr}, 0);
        check_eq("rst_we", {31'd0, mem_we}, 0);
        check_eq("rst_rd", {31'd0, mem_rd}, 0);
        check_eq("rst_strobe", {31'd0, sd_dout_strobe}, 0);
        check_eq("rst_err", {31'd0, err}, 0);
        check_eq("rst_state", {30'd0, dbg_state}, 0);

        // Mount: size next cycle, single pulse two cycles after mount
        mount = 1'b1;
        @(posedge clk_sys); #1;
        mount = 1'b0;
        check_eq("mnt_size", img_size, 32'd8192);
        check_eq("mnt_early", {31'd0, img_mounted}, 0);
        @(posedge clk_sys); #1;
        check_eq("mnt_pulse", {31'd0, img_mounted}, 1);
        @(posedge clk_sys); #1;
        check_eq("mnt_end", {31'd0, img_mounted}, 0);
        check_eq("mnt_cnt", 32'(mnt_cnt), 1);

        // Read LBA 3
        rd_cnt = 0; err_cnt = 0;
        push_read(4'h3, 1'b0);
        run_xfer(1'b1, 1'b0, 32'd3, 1);
        settle("rd3");
        check_eq("rd3_memrd", 32'(rd_cnt), 512);
        check_eq("rd3_err", 32'(err_cnt), 0);

        // Write LBA 5, buffer returns ~addr
        buf_seed = 8'hFF; err_cnt = 0;
        push_write(4'd5, 8'hFF, 512);
        run_xfer(1'b0, 1'b1, 32'd5, 1);
        settle("wr5");
        check_eq("wr5_mem0", {24'd0, mem[{4'd5, 9'd0}]}, 32'hFF);
        check_eq("wr5_mem511", {24'd0, mem[{4'd5, 9'd511}]}, 32'h00);
        check_eq("wr5_mem130", {24'd0, mem[{4'd5, 9'd130}]}, 32'h7D);
        check_eq("wr5_err", 32'(err_cnt), 0);

        // Out-of-range read
        rd_cnt = 0; err_cnt = 0;
        push_read(4'h0, 1'b1);
        run_xfer(1'b1, 1'b0, 32'd16, 1);
        settle("oor_rd");
        check_eq("oor_rd_err", 32'(err_cnt), 1);
        check_eq("oor_rd_memrd", 32'(rd_cnt), 0);

        // Out-of-range write: nothing reaches memory (sector 0 would alias)
        err_cnt = 0; buf_seed = 8'h3C;
        run_xfer(1'b0, 1'b1, 32'h0001_0010, 1);
        settle("oor_wr");
        check_eq("oor_wr_err", 32'(err_cnt), 1);
        check_eq("oor_wr_mem0", {24'd0, mem[13'd0]}, 32'h00);
        check_eq("oor_wr_mem5", {24'd0, mem[13'd5]}, 32'h05);

        // sd_rd and sd_wr together: read wins
        push_read(4'h3, 1'b0);
        run_xfer(1'b1, 1'b1, 32'd3, 1);
        settle("both");
        check_eq("both_mem3", {24'd0, mem[{4'd3, 9'd7}]}, 32'h37);

        // Mount during a read of LBA 2
        mnt_cnt = 0;
        push_read(4'h2, 1'b0);
        fork
            run_xfer(1'b1, 1'b0, 32'd2, 1);
            begin
                repeat (300) @(posedge clk_sys);
                #1 mount = 1'b1;
                @(posedge clk_sys);
                #1 mount = 1'b0;
            end
        join
        settle("mnt_xfer");
        check_eq("mnt_xfer_cnt", 32'(mnt_cnt), 1);
        check_eq("mnt_xfer_size", img_size, 32'd8192);

        // 16-sector save loop, next request raised on ack fall
        for (int s = 0; s < 16; s++) begin
            buf_seed = save_seed(s);
            push_write(4'(s), save_seed(s), 512);
            run_xfer(1'b0, 1'b1, 32'(s), (s == 0) ? 1 : 2);
        end
        settle("save");
        for (int s = 0; s < 16; s++) begin
            for (int k = 0; k < 512; k += 37) begin
                logic [8:0] kk;
                kk = 9'(k);
                check_eq("save_mem", {24'd0, mem[{4'(s), kk}]},
                         {24'd0, save_seed(s) ^ kk[7:0]});
            end
        end

        // Reset at byte 100 of a write to LBA 7
        buf_seed = 8'h5A;
        push_write(4'd7, 8'h5A, 100);
        sd_lba = 32'd7; sd_wr = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_sys); #1;
            if (sd_ack) sd_wr = 1'b0;
            if (sd_ack && sd_buff_addr == 9'd100) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("rstx_found", {31'd0, found}, 1);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        check_eq("rstx_ack", {31'd0, sd_ack}, 0);
        check_eq("rstx_state", {30'd0, dbg_state}, 0);
        check_eq("rstx_size", img_size, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_eq("rstx_wrq", 32'(wr_exp_q.size()), 0);
        check_eq("rstx_xwe", 32'(extra_we), 0);
        check_eq("rstx_mem99", {24'd0, mem[{4'd7, 9'd99}]}, {24'd0, 8'h5A ^ 8'd99});
        check_eq("rstx_mem100", {24'd0, mem[{4'd7, 9'd100}]}, {24'd0, save_seed(7) ^ 8'd100});
        check_eq("rstx_mem511", {24'd0, mem[{4'd7, 9'd511}]}, {24'd0, save_seed(7) ^ 8'hFF});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Target (responder) end of the sd_lba / sd_rd / sd_wr / sd_ack sector-transfer protocol that the core's save-RAM backup logic drives as initiator.
- Serves 512-byte sector reads and writes from a byte-wide synchronous backing memory, which can be BRAM or an SDRAM port adapter.
- Also emits img_mounted / img_size on a mount request.
- Used for standalone save-RAM persistence without the SPI host, and as the bench model for every core-side initiator.

Parameters:
- LBA_BITS, 4: LBA bits mapped to backing memory; the image holds 2^LBA_BITS sectors.
- ACK_DELAY, 4: cycles from request acceptance to sd_ack rise. Minimum 1.
- BYTE_CYCLES, 2: clk_sys cycles per transferred byte. Minimum 2.
- FILL_BYTE, 8'hFF: data returned for out-of-range reads.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- sd_lba  in  32  sector address, stable while sd_rd or sd_wr is high
- sd_rd  in  1  read request (level)
- sd_wr  in  1  write request (level)
- sd_ack  out  1  transfer in progress
- sd_buff_addr  out  9  byte index within the sector
- sd_dout  out  8  read data to the initiator
- sd_dout_strobe  out  1  one-cycle pulse: sd_dout/sd_buff_addr valid
- sd_din  in  8  write data from the initiator buffer (1-cycle read latency vs sd_buff_addr)
- mem_addr  out  LBA_BITS+9  backing address {lba, byte}
- mem_rd  out  1  backing read; mem_rdata valid the next cycle
- mem_rdata  in  8  backing read data
- mem_we  out  1  backing write pulse
- mem_wdata  out  8  backing write data
- mount  in  1  pulse: present image
- img_mounted  out  1  one-cycle pulse, 2 cycles after mount
- img_size  out  32  image size in bytes = 512<<LBA_BITS, else 0 before first mount
- err  out  1  one-cycle pulse on an out-of-range request

Behaviour:
- Reset values: all outputs 0, img_size 0, state IDLE. Reset mid-transfer aborts immediately: sd_ack drops, no further mem_we, partial sector left as written.
- IDLE:
  - Sample sd_rd/sd_wr each cycle. If both are high, read wins.
  - On acceptance, latch sd_lba and direction.
  - Out of range means sd_lba[31:LBA_BITS] != 0. Pulse err; reads return FILL_BYTE; writes are discarded (mem_we stays 0).
  - Go to WAIT.
- WAIT: count ACK_DELAY cycles, then set sd_ack=1, byte counter=0, go to XFER.
- XFER, read; per byte k, period of BYTE_CYCLES:
  - Cycle 0: mem_addr={lba,k}, mem_rd=1.
  - Cycle 1: register mem_rdata into sd_dout, set sd_buff_addr=k, pulse sd_dout_strobe. Strobe and data are coincident.
- XFER, write; per byte k:
  - Cycle 0: sd_buff_addr=k.
  - Cycle 1: capture sd_din, then mem_we=1, mem_addr={lba,k}, mem_wdata=sd_din.
- Counter wrap: after k=511, go to DONE. The counter is 9 bits and must not wrap into a second sector.
- DONE:
  - sd_ack=0 for one cycle, sd_buff_addr returns to 0, then IDLE.
  - The initiator clears sd_rd/sd_wr on the ack rise; if a request is high again in IDLE (next-sector chaining on ack fall), it is accepted normally.
- Requests raised while not in IDLE are ignored until IDLE; they are level-held, so none is lost.
- sd_rd/sd_wr deasserting before ack does not cancel the transfer.
- Mount: img_size updates the cycle after mount; img_mounted pulses one cycle later. Mount during a transfer does not disturb it.
- Total transfer: sd_ack high for exactly 512*BYTE_CYCLES cycles.

Decomposition:
- Shared package sd_pkg:
  - state enum {IDLE, WAIT, XFER, DONE}
  - SECTOR_BYTES=512
  - SECTOR_AW=9
- One natural sub-module: sd_byte_sequencer, which holds the byte counter, BYTE_CYCLES phase counter, strobe/we generation and the last-byte flag. The FSM and mount logic stay in the top.

Test Plan:
- Read, LBA 3:
  - Stimulus: memory preloaded with byte={lba[3:0],addr[3:0]}; sd_rd=1, sd_lba=3.
  - Response: sd_ack rises 4 cycles after acceptance; 512 strobes with sd_dout=8'h3X at addrs 0..511; ack high exactly 1024 cycles.
- Write, LBA 5:
  - Stimulus: initiator buffer returns ~addr[7:0] with 1-cycle latency.
  - Response: 512 mem_we pulses at {5,k} with data ~k[7:0]; no strobes.
- 16-sector save loop:
  - Stimulus: initiator chains sd_lba 0..15 on ack fall.
  - Response: all 8192 bytes written, no skipped or duplicated sector.
- Out-of-range, sd_lba=16:
  - Read: err pulse, 512 strobes of 8'hFF, no mem_rd to a wrapped address.
  - Write: err pulse, zero mem_we.
- sd_rd and sd_wr high together: read performed. Reset asserted at byte 100 of a write: sd_ack 0 next cycle, bytes 0..99 written, 100+ untouched.
- Mount pulse: img_size=8192 one cycle later, img_mounted single pulse two cycles later. A mount during a transfer leaves the transfer unaffected.
